// File: rtl/mac_seq_ctrl.sv
// Job sequencer for one mul->acc MAC lane: admits N*K operand beats, tags them through the
// lane latency, qualifies each K-sum with m_valid/m_ready and stalls the lane on backpressure.
//   state    | meaning
//   ST_IDLE  | waiting for a job config (cfg_ready=1)
//   ST_RUN   | admitting operand beats until N groups of K are in
//   ST_DRAIN | all beats in, waiting for the last result handshake
module mac_seq_ctrl #(
  parameter int K_MAX = 256,
  parameter int N_MAX = 65535,
  parameter int LM    = 1,
  parameter int LA    = 1,
  parameter int WKC   = $clog2(K_MAX + 1),
  parameter int WNC   = $clog2(N_MAX + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [WKC-1:0] cfg_k,
  input  logic [WNC-1:0] cfg_n,
  input  logic           s_valid,
  output logic           s_ready,
  output logic           mac_rstn,
  output logic           mac_en,
  output logic           mac_x_valid,
  output logic           mac_first,
  output logic           m_valid,
  input  logic           m_ready,
  output logic           busy,
  output logic           done
);

  localparam int P = LM + LA;
  localparam logic [WKC-1:0] K_MAX_C = WKC'(K_MAX);
  localparam logic [WNC-1:0] N_MAX_C = WNC'(N_MAX);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  state_t         state_q, state_d;
  logic [WKC-1:0] k_q, k_d, kc_q, kc_d;
  logic [WNC-1:0] n_q, n_d, nin_q, nin_d, nout_q, nout_d;
  logic [WNC-1:0] nin_inc;
  logic           zdone_q, zdone_d;
  logic [P-1:0]   v_q, v_d, last_q, last_d;
  logic [LM-1:0]  first_q, first_d;
  logic           beat, out_hs, last_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      n_q     <= '0;
      kc_q    <= '0;
      nin_q   <= '0;
      nout_q  <= '0;
      zdone_q <= 1'b0;
      v_q     <= '0;
      last_q  <= '0;
      first_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      n_q     <= n_d;
      kc_q    <= kc_d;
      nin_q   <= nin_d;
      nout_q  <= nout_d;
      zdone_q <= zdone_d;
      v_q     <= v_d;
      last_q  <= last_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    mac_rstn    = ~rst;
    m_valid     = v_q[P-1] & last_q[P-1];
    mac_en      = ~(m_valid & ~m_ready);
    mac_x_valid = v_q[LM-1];
    mac_first   = v_q[LM-1] & first_q[LM-1];
    cfg_ready   = (state_q == ST_IDLE);
    busy        = (state_q != ST_IDLE);
    s_ready     = (state_q == ST_RUN) & mac_en;
    beat        = s_valid & s_ready;
    out_hs      = m_valid & m_ready;
    last_out    = out_hs & (nout_q == n_q - 1'b1);
    done        = zdone_q | ((state_q == ST_DRAIN) & last_out);
    nin_inc     = nin_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    n_d     = n_q;
    kc_d    = kc_q;
    nin_d   = nin_q;
    nout_d  = nout_q;
    zdone_d = 1'b0;
    v_d     = v_q;
    last_d  = last_q;
    first_d = first_q;

    // Tag pipe moves in lockstep with the lane; only the first LM stages need the first flag.
    if (mac_en) begin
      for (int i = P - 1; i > 0; i--) begin
        v_d[i]    = v_q[i-1];
        last_d[i] = last_q[i-1];
      end
      for (int i = LM - 1; i > 0; i--) begin
        first_d[i] = first_q[i-1];
      end
      v_d[0]     = beat;
      last_d[0]  = (kc_q == k_q - 1'b1);
      first_d[0] = (kc_q == '0);
    end

    if (out_hs) nout_d = nout_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          k_d    = cfg_k;
          n_d    = cfg_n;
          kc_d   = '0;
          nin_d  = '0;
          nout_d = '0;
          if (cfg_k == '0 || cfg_n == '0) zdone_d = 1'b1;
          else                            state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (beat) begin
          if (kc_q == k_q - 1'b1) begin
            kc_d  = '0;
            nin_d = nin_inc;
            if (nin_inc == n_q) state_d = ST_DRAIN;
          end else begin
            kc_d = kc_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (last_out) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  cfg_legal_a: assert property (@(posedge clk) disable iff (rst)
    (cfg_valid && cfg_ready) |-> (cfg_k <= K_MAX_C && cfg_n <= N_MAX_C));

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: a behavioural mul/acc lane driven by the controller, with results
// compared against per-job K-group dot products computed from the stimulus.
module tb_mac_seq_ctrl;
  localparam int K_MAX = 256;
  localparam int N_MAX = 65535;
  localparam int LM    = 1;
  localparam int LA    = 1;
  localparam int WKC   = $clog2(K_MAX + 1);
  localparam int WNC   = $clog2(N_MAX + 1);

  logic           clk = 1'b0;
  logic           rst, cfg_valid, cfg_ready, s_valid, s_ready;
  logic           mac_rstn, mac_en, mac_x_valid, mac_first, m_valid, m_ready, busy, done;
  logic [WKC-1:0] cfg_k;
  logic [WNC-1:0] cfg_n;

  int checks = 0;
  int failures = 0;
  int x_in, w_in;
  int xq[$], wq[$];

  mac_seq_ctrl #(.K_MAX(K_MAX), .N_MAX(N_MAX), .LM(LM), .LA(LA), .WKC(WKC), .WNC(WNC)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_k(cfg_k),
    .cfg_n(cfg_n), .s_valid(s_valid), .s_ready(s_ready), .mac_rstn(mac_rstn), .mac_en(mac_en),
    .mac_x_valid(mac_x_valid), .mac_first(mac_first), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural lane: LM-cycle multiplier feeding an accumulator whose output is LA cycles late.
  int mulp [LM];
  int ypipe [LA];
  int acc_s, acc_nxt, y_lane;

  always_comb begin
    acc_nxt = acc_s;
    if (mac_x_valid) acc_nxt = mac_first ? mulp[LM-1] : acc_s + mulp[LM-1];
  end
  assign y_lane = ypipe[LA-1];

  always @(posedge clk) begin
    if (!mac_rstn) begin
      for (int i = 0; i < LM; i++) mulp[i] <= 0;
      for (int i = 0; i < LA; i++) ypipe[i] <= 0;
      acc_s <= 0;
    end else if (mac_en) begin
      mulp[0] <= x_in * w_in;
      for (int i = 1; i < LM; i++) mulp[i] <= mulp[i-1];
      acc_s    <= acc_nxt;
      ypipe[0] <= acc_nxt;
      for (int i = 1; i < LA; i++) ypipe[i] <= ypipe[i-1];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic run_job(input int k, input int n, input int stall, input bit rnd);
    int total, sent, got, cyc, stall_left, s, idx, lat;
    int bc[$];
    int expq[$];
    bit seen, hs;
    total = k * n; sent = 0; got = 0; cyc = 0; stall_left = 0; seen = 1'b0;
    while (xq.size() < total) begin
      xq.push_back(int'($urandom_range(40)) - 20);
      wq.push_back(int'($urandom_range(10)) - 5);
    end
    for (int j = 0; j < n; j++) begin
      s = 0;
      for (int i = 0; i < k; i++) s += xq[j*k+i] * wq[j*k+i];
      expq.push_back(s);
    end
    @(negedge clk);
    cfg_valid = 1'b1; cfg_k = WKC'(k); cfg_n = WNC'(n);
    #1 chk("cfg_ready_idle", cfg_ready, 1);
    @(negedge clk);
    cfg_valid = 1'b0;
    while (got < n && cyc < 2000) begin
      if (m_valid && !seen && stall > 0) begin
        seen = 1'b1;
        stall_left = stall;
      end
      s_valid   = (sent < total) && (rnd ? ($urandom_range(1) == 1) : 1'b1);
      x_in      = (sent < total) ? xq[sent] : 0;
      w_in      = (sent < total) ? wq[sent] : 0;
      m_ready   = (stall_left > 0) ? 1'b0 : (rnd ? ($urandom_range(3) != 0) : 1'b1);
      cfg_valid = rnd ? ($urandom_range(1) == 1) : 1'b0;
      cfg_k     = '0;
      #1;
      chk("cfg_ready_busy", cfg_ready, 0);
      if (stall_left > 0) begin
        chk("stall_mac_en", mac_en, 0);
        chk("stall_s_ready", s_ready, 0);
        chk("stall_y_hold", y_lane, expq[0]);
        stall_left--;
      end
      if (sent == total && total > 0 && cyc > bc[total-1]) chk("s_ready_after_last", s_ready, 0);
      hs = m_valid && m_ready;
      chk("done", done, hs && (got == n - 1));
      if (s_valid && s_ready) begin
        bc.push_back(cyc);
        sent++;
      end
      if (hs) begin
        chk("result", y_lane, expq[got]);
        if (!rnd && stall == 0) begin
          idx = (got + 1) * k - 1;
          lat = (bc.size() > idx) ? cyc - bc[idx] : -1;
          chk("result_latency", lat, LM + LA);
        end
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("job_complete", got, n);
    s_valid = 1'b0; cfg_valid = 1'b0; m_ready = 1'b1; x_in = 0; w_in = 0;
    #1 chk("idle_after_job", busy, 0);
    xq.delete();
    wq.delete();
  endtask

  task automatic zero_job(input int k, input int n);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_k = WKC'(k); cfg_n = WNC'(n); s_valid = 1'b1;
    #1 chk("zero_cfg_ready", cfg_ready, 1);
    chk("zero_no_early_done", done, 0);
    @(negedge clk);
    cfg_valid = 1'b0;
    #1 chk("zero_done", done, 1);
    chk("zero_s_ready", s_ready, 0);
    @(negedge clk);
    #1 chk("zero_done_once", done, 0);
    chk("zero_s_ready_2", s_ready, 0);
    chk("zero_busy", busy, 0);
    s_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_k = '0; cfg_n = '0;
    s_valid = 1'b0; m_ready = 1'b1; x_in = 0; w_in = 0;

    // reset
    repeat (3) @(negedge clk);
    #1 chk("rstn_in_reset", mac_rstn, 0);
    rst = 1'b0;
    #1 chk("rstn_released", mac_rstn, 1);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mac_en", mac_en, 1);

    // K=4, N=2, x=1..8, w=1 -> 10, 26
    for (int i = 1; i <= 8; i++) begin xq.push_back(i); wq.push_back(1); end
    run_job(4, 2, 0, 1'b0);

    // same job with a 5-cycle consumer stall on the first result
    for (int i = 1; i <= 8; i++) begin xq.push_back(i); wq.push_back(1); end
    run_job(4, 2, 5, 1'b0);

    // K=1: one result per beat
    xq = '{3, -2, 7}; wq = '{2, 2, 2};
    run_job(1, 3, 0, 1'b0);

    // degenerate configs
    zero_job(0, 5);
    zero_job(3, 0);

    // abort after 3 of 8 beats, then a fresh job must not see the partial sum
    @(negedge clk);
    cfg_valid = 1'b1; cfg_k = WKC'(8); cfg_n = WNC'(1);
    @(negedge clk);
    cfg_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; x_in = 9 + i; w_in = 3; m_ready = 1'b1;
      @(negedge clk);
    end
    s_valid = 1'b0; rst = 1'b1;
    #1 chk("abort_rstn", mac_rstn, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("abort_busy", busy, 0);
    chk("abort_cfg_ready", cfg_ready, 1);
    chk("abort_m_valid", m_valid, 0);
    chk("abort_no_done", done, 0);
    xq = '{5, 5}; wq = '{1, 1};
    run_job(2, 1, 0, 1'b0);

    // randomized jobs with random source/consumer handshakes
    for (int j = 0; j < 6; j++) begin
      run_job(int'($urandom_range(1, 6)), int'($urandom_range(1, 4)),
              int'($urandom_range(0, 3)), 1'b1);
    end
    // full-rate random job with latency checks
    run_job(3, 4, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
